// File: rtl/z80_bus_responder.sv
// z80_bus_responder
// Bus slave for an active-high Z80-style CPU bus. It decodes memory, I/O and
// interrupt-acknowledge cycles, stretches each one with per-region wait
// states, drives a 1-cycle-latency synchronous memory, and hosts a small I/O
// block: two scratch registers and a 16-bit opcode-fetch counter with a
// high-byte shadow.
//
// Handshake: a request is REQ = MREQ | IORQ. While REQ is high the responder
// holds WAIT high until the access completes. WAIT is low in the one DONE
// cycle, and that is the cycle in which read data is valid on DI. The CPU must
// keep ADDR/WR/CPU_DO stable only in the first (IDLE) cycle; the responder
// latches them there. Dropping REQ before DONE aborts the access with no side
// effects.
//
// DBG_STATE exposes the FSM state: 0 = IDLE, 1 = CNT, 2 = DONE.
module z80_bus_responder #(
    parameter int unsigned ROM_WS   = 1,
    parameter int unsigned RAM_WS   = 0,
    parameter int unsigned M1_EXTRA = 0,
    parameter int unsigned IO_WS    = 1,
    parameter logic [7:0]  IO_BASE  = 8'h10
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] ADDR,
    input  logic [7:0]  CPU_DO,
    input  logic        WR,
    input  logic        MREQ,
    input  logic        IORQ,
    input  logic        M1,
    output logic [7:0]  DI,
    output logic        WAIT,
    output logic [15:0] MEM_ADDR,
    output logic [7:0]  MEM_DI,
    output logic        MEM_WE,
    output logic        MEM_RE,
    input  logic [7:0]  MEM_DO,
    output logic [15:0] FETCH_CNT,
    output logic [1:0]  DBG_STATE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CNT  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_MEM  = 2'd0,
        CLS_IO   = 2'd1,
        CLS_INTA = 2'd2
    } cls_t;

    // Wait counts are at most 15 + 15, so five bits hold any total.
    localparam logic [4:0] ROM_N = 5'(ROM_WS);
    localparam logic [4:0] RAM_N = 5'(RAM_WS);
    localparam logic [4:0] M1X_N = 5'(M1_EXTRA);
    localparam logic [4:0] IO_N  = 5'(IO_WS);

    state_t      state;
    logic [4:0]  cnt;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic        wr_q;
    logic        m1_q;
    cls_t        cls_q;

    logic [7:0]  scratch0;
    logic [7:0]  scratch1;
    logic [7:0]  shadow;
    logic [15:0] fetch_cnt;

    logic        req;
    cls_t        live_cls;
    logic [4:0]  live_n;
    logic        io_hit;
    logic [7:0]  io_rd;
    logic        strobe;
    logic        stb_wr;

    // Classify the live request and work out how many wait cycles it needs.
    always_comb begin
        req      = MREQ | IORQ;
        live_cls = CLS_MEM;
        if (IORQ) begin
            live_cls = M1 ? CLS_INTA : CLS_IO;
        end
        if (live_cls == CLS_MEM) begin
            live_n = (ADDR[15] ? RAM_N : ROM_N) + (M1 ? M1X_N : 5'd0);
        end else begin
            live_n = IO_N;
        end
    end

    // Access sequencer: latch the request in IDLE, count waits, finish in DONE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            addr_q <= 16'h0000;
            data_q <= 8'h00;
            wr_q   <= 1'b0;
            m1_q   <= 1'b0;
            cls_q  <= CLS_MEM;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= ADDR;
                        data_q <= CPU_DO;
                        wr_q   <= WR;
                        m1_q   <= M1;
                        cls_q  <= live_cls;
                        cnt    <= live_n;
                        state  <= (live_n == 5'd0) ? DONE : CNT;
                    end
                end
                CNT: begin
                    if (!req) begin
                        // CPU gave up on the cycle: no strobe, no side effects.
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd1) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign io_hit = (cls_q == CLS_IO) && (addr_q[7:2] == IO_BASE[7:2]);

    // I/O register writes, shadow capture and fetch counting, all at the end of DONE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            scratch0  <= 8'h00;
            scratch1  <= 8'h00;
            shadow    <= 8'h00;
            fetch_cnt <= 16'h0000;
        end else if (state == DONE) begin
            if (cls_q == CLS_MEM && m1_q) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (io_hit) begin
                if (wr_q) begin
                    case (addr_q[1:0])
                        2'd0:    scratch0  <= data_q;
                        2'd1:    scratch1  <= data_q;
                        2'd2:    fetch_cnt <= 16'h0000;
                        default: ;
                    endcase
                end else if (addr_q[1:0] == 2'd2) begin
                    // Reading the low byte freezes the high byte for a coherent 16-bit read.
                    shadow <= fetch_cnt[15:8];
                end
            end
        end
    end

    // Bus-side outputs: memory strobes, address/data mux, WAIT and read data.
    always_comb begin
        strobe = 1'b0;
        stb_wr = (state == IDLE) ? WR : wr_q;
        if (!RESET && req) begin
            if (state == IDLE) begin
                strobe = (live_cls == CLS_MEM) && (live_n == 5'd0);
            end else if (state == CNT) begin
                strobe = (cls_q == CLS_MEM) && (cnt == 5'd1);
            end
        end
        MEM_RE = strobe && !stb_wr;
        MEM_WE = strobe && stb_wr;

        WAIT = !RESET && req && (state != DONE);

        MEM_ADDR = 16'h0000;
        MEM_DI   = 8'h00;
        if (!RESET) begin
            if (state == IDLE) begin
                MEM_ADDR = ADDR;
                MEM_DI   = CPU_DO;
            end else begin
                MEM_ADDR = addr_q;
                MEM_DI   = data_q;
            end
        end

        case (addr_q[1:0])
            2'd0:    io_rd = scratch0;
            2'd1:    io_rd = scratch1;
            2'd2:    io_rd = fetch_cnt[7:0];
            default: io_rd = shadow;
        endcase

        // Undriven bus reads as 8'hFF; an interrupt ack therefore fetches RST 38h.
        DI = 8'hFF;
        if (!RESET && state == DONE && !wr_q) begin
            if (cls_q == CLS_MEM) begin
                DI = MEM_DO;
            end else if (io_hit) begin
                DI = io_rd;
            end
        end
    end

    assign FETCH_CNT = fetch_cnt;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Bench for z80_bus_responder: a transaction-level model predicts every cycle of
// each access; a compare process checks the DUT against those predictions, and
// literal expectations pin the model to known results.
module tb_z80_bus_responder;

    localparam int         ROM_WS_P  = 1;
    localparam int         RAM_WS_P  = 0;
    localparam int         M1X_P     = 0;
    localparam int         IO_WS_P   = 1;
    localparam logic [7:0] IO_BASE_P = 8'h10;

    typedef struct packed {
        logic        wt;
        logic        re;
        logic        we;
        logic [15:0] sa;
        logic [7:0]  sd;
        logic [7:0]  di;
        logic [15:0] fc;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] addr   = 16'h0000;
    logic [7:0]  cpu_do = 8'h00;
    logic        wr     = 1'b0;
    logic        mreq   = 1'b0;
    logic        iorq   = 1'b0;
    logic        m1     = 1'b0;
    logic [7:0]  mem_do = 8'h00;
    logic [7:0]  di;
    logic        wait_o;
    logic [15:0] mem_addr;
    logic [7:0]  mem_di;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] fetch_cnt;
    logic [1:0]  dbg_state;

    // Second instance with ROM_WS=3, used only for the abort scenario.
    logic        mreq3  = 1'b0;
    logic        iorq3  = 1'b0;
    logic [7:0]  mem_do3 = 8'h00;
    logic [7:0]  di3;
    logic        wait3;
    logic [15:0] mem_addr3;
    logic [7:0]  mem_di3;
    logic        mem_we3;
    logic        mem_re3;
    logic [15:0] fetch_cnt3;
    logic [1:0]  dbg_state3;

    z80_bus_responder #(
        .ROM_WS(ROM_WS_P), .RAM_WS(RAM_WS_P), .M1_EXTRA(M1X_P),
        .IO_WS(IO_WS_P), .IO_BASE(IO_BASE_P)
    ) dut (
        .CLK(clk), .RESET(rst), .ADDR(addr), .CPU_DO(cpu_do), .WR(wr),
        .MREQ(mreq), .IORQ(iorq), .M1(m1), .DI(di), .WAIT(wait_o),
        .MEM_ADDR(mem_addr), .MEM_DI(mem_di), .MEM_WE(mem_we), .MEM_RE(mem_re),
        .MEM_DO(mem_do), .FETCH_CNT(fetch_cnt), .DBG_STATE(dbg_state)
    );

    z80_bus_responder #(
        .ROM_WS(3), .RAM_WS(0), .M1_EXTRA(0), .IO_WS(1), .IO_BASE(8'h10)
    ) dut3 (
        .CLK(clk), .RESET(rst), .ADDR(addr), .CPU_DO(cpu_do), .WR(wr),
        .MREQ(mreq3), .IORQ(iorq3), .M1(m1), .DI(di3), .WAIT(wait3),
        .MEM_ADDR(mem_addr3), .MEM_DI(mem_di3), .MEM_WE(mem_we3), .MEM_RE(mem_re3),
        .MEM_DO(mem_do3), .FETCH_CNT(fetch_cnt3), .DBG_STATE(dbg_state3)
    );

    // ---------------- external synchronous memory ----------------
    logic [7:0] mem_arr [0:65535];

    function automatic logic [7:0] mem_init(input logic [15:0] a);
        case (a)
            16'h0000: return 8'h3E;
            16'h0004: return 8'hC7;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) mem_arr[i] = mem_init(16'(i));
        forever begin
            @(posedge clk);
            if (mem_we) mem_arr[mem_addr] = mem_di;
            if (mem_re) mem_do <= mem_arr[mem_addr];
            if (mem_re3) mem_do3 <= mem_arr[mem_addr3];
        end
    end

    // ---------------- scoreboard / model state ----------------
    exp_t        exp_q[$];
    logic [7:0]  ref_w [logic [15:0]];
    logic [15:0] m_fc = 16'h0000;
    logic [7:0]  m_s0 = 8'h00;
    logic [7:0]  m_s1 = 8'h00;
    logic [7:0]  m_sh = 8'h00;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (ref_w.exists(a)) return ref_w[a];
        return mem_init(a);
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int cycles);
        exp_t e;
        for (int k = 0; k < cycles; k++) begin
            mreq = 1'b0; iorq = 1'b0; m1 = 1'b0; wr = 1'b0;
            e = '{wt: 1'b0, re: 1'b0, we: 1'b0, sa: 16'h0, sd: 8'h0, di: 8'hFF, fc: m_fc};
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    // One complete bus access with REQ held through DONE. Returns DI seen in the
    // final cycle and the number of cycles WAIT was observed high.
    task automatic access(input logic is_io, input logic is_m1, input logic is_wr,
                          input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] got_di, output int got_wcnt);
        int         n;
        int         off;
        logic       hit;
        logic       is_mem;
        logic [7:0] rd;
        exp_t       e;
        is_mem = !is_io;
        if (is_io) n = IO_WS_P;
        else n = (a[15] ? RAM_WS_P : ROM_WS_P) + (is_m1 ? M1X_P : 0);
        off = int'(a[7:0]) - int'(IO_BASE_P);
        hit = is_io && !is_m1 && off >= 0 && off <= 3;
        rd = 8'hFF;
        if (!is_wr) begin
            if (is_mem) rd = ref_read(a);
            else if (hit) begin
                case (off)
                    0: rd = m_s0;
                    1: rd = m_s1;
                    2: rd = m_fc[7:0];
                    default: rd = m_sh;
                endcase
            end
        end
        got_wcnt = 0;
        got_di = 8'h00;
        for (int k = 0; k < n + 2; k++) begin
            mreq = is_mem; iorq = is_io; m1 = is_m1; wr = is_wr; addr = a; cpu_do = d;
            e.wt = (k <= n);
            e.re = (k == n) && is_mem && !is_wr;
            e.we = (k == n) && is_mem && is_wr;
            e.sa = a;
            e.sd = d;
            e.di = (k == n + 1) ? rd : 8'hFF;
            e.fc = m_fc;
            exp_q.push_back(e);
            @(negedge clk);
            if (wait_o) got_wcnt++;
            got_di = di;
            @(posedge clk); #1;
        end
        if (is_mem && is_wr) ref_w[a] = d;
        if (is_mem && is_m1) m_fc = m_fc + 16'd1;
        if (hit) begin
            if (is_wr) begin
                case (off)
                    0: m_s0 = d;
                    1: m_s1 = d;
                    2: m_fc = 16'h0000;
                    default: ;
                endcase
            end else if (off == 2) begin
                m_sh = m_fc[15:8];
            end
        end
    endtask

    // ---------------- compare process ----------------
    exp_t ce;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            chk("wait", 32'(wait_o), 32'(ce.wt));
            chk("mem_re", 32'(mem_re), 32'(ce.re));
            chk("mem_we", 32'(mem_we), 32'(ce.we));
            chk("di", 32'(di), 32'(ce.di));
            chk("fetch_cnt", 32'(fetch_cnt), 32'(ce.fc));
            if (ce.re || ce.we) chk("mem_addr", 32'(mem_addr), 32'(ce.sa));
            if (ce.we) chk("mem_di", 32'(mem_di), 32'(ce.sd));
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] g_di;
    int         g_w;
    int         re_cnt;

    initial begin
        // Reset with a zero-wait RAM read request already present on the bus.
        mreq = 1'b1; addr = 16'h8000; wr = 1'b0;
        #3;
        chk("rst_wait", 32'(wait_o), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_di", 32'(di), 32'h0FF);
        chk("rst_fc", 32'(fetch_cnt), 0);
        chk("rst_state", 32'(dbg_state), 0);
        @(posedge clk); #1;
        mreq = 1'b0; addr = 16'h0000;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // ROM opcode fetch, one wait state.
        access(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, g_di, g_w);
        chk("rom_fetch_di", 32'(g_di), 32'h3E);
        chk("rom_fetch_wait_cycles", 32'(g_w), 2);
        chk("rom_fetch_fc", 32'(fetch_cnt), 1);

        // RAM write with no wait, then back-to-back read of the same byte.
        access(1'b0, 1'b0, 1'b1, 16'h8001, 8'hA5, g_di, g_w);
        chk("ram_wr_wait_cycles", 32'(g_w), 1);
        chk("ram_wr_fc", 32'(fetch_cnt), 1);
        access(1'b0, 1'b0, 1'b0, 16'h8001, 8'h00, g_di, g_w);
        chk("ram_rd_back", 32'(g_di), 32'hA5);
        idle(1);

        // I/O scratch registers, undecoded port, read-only shadow.
        access(1'b1, 1'b0, 1'b1, 16'h0011, 8'h5A, g_di, g_w);
        chk("io_wr_wait_cycles", 32'(g_w), 2);
        access(1'b1, 1'b0, 1'b0, 16'h0011, 8'h00, g_di, g_w);
        chk("io_rd_11", 32'(g_di), 32'h5A);
        access(1'b1, 1'b0, 1'b0, 16'h0020, 8'h00, g_di, g_w);
        chk("io_rd_undecoded", 32'(g_di), 32'hFF);
        chk("io_undecoded_wait_cycles", 32'(g_w), 2);
        access(1'b1, 1'b0, 1'b1, 16'h0010, 8'h3C, g_di, g_w);
        access(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00, g_di, g_w);
        chk("io_rd_10", 32'(g_di), 32'h3C);
        access(1'b1, 1'b0, 1'b1, 16'h0013, 8'h77, g_di, g_w);
        access(1'b1, 1'b0, 1'b0, 16'h0013, 8'h00, g_di, g_w);
        chk("io_rd_13_ro", 32'(g_di), 32'h00);
        idle(1);

        // Interrupt acknowledge.
        access(1'b1, 1'b1, 1'b0, 16'h0038, 8'h00, g_di, g_w);
        chk("inta_di", 32'(g_di), 32'hFF);
        chk("inta_fc", 32'(fetch_cnt), 1);
        idle(1);

        // Counter wrap: start from FFFF, one more fetch wraps to zero.
        force dut.fetch_cnt = 16'hFFFF;
        m_fc = 16'hFFFF;
        idle(1);
        release dut.fetch_cnt;
        idle(1);
        access(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00, g_di, g_w);
        chk("fc_wrap", 32'(fetch_cnt), 0);
        for (int i = 0; i < 16'h0102; i++) begin
            access(1'b0, 1'b1, 1'b0, 16'(16'h8100 + i), 8'h00, g_di, g_w);
        end
        chk("fc_0102", 32'(fetch_cnt), 32'h0102);
        access(1'b1, 1'b0, 1'b0, 16'h0012, 8'h00, g_di, g_w);
        chk("io_rd_fc_lo", 32'(g_di), 32'h02);
        access(1'b1, 1'b0, 1'b0, 16'h0013, 8'h00, g_di, g_w);
        chk("io_rd_fc_hi", 32'(g_di), 32'h01);
        access(1'b1, 1'b0, 1'b1, 16'h0012, 8'h99, g_di, g_w);
        chk("fc_clear", 32'(fetch_cnt), 0);
        access(1'b0, 1'b1, 1'b0, 16'h8002, 8'h00, g_di, g_w);
        access(1'b0, 1'b1, 1'b0, 16'h0001, 8'h00, g_di, g_w);
        chk("fc_after_clear", 32'(fetch_cnt), 2);
        idle(2);

        // Abort on the ROM_WS=3 instance: drop MREQ in the second CNT cycle.
        addr = 16'h0004; m1 = 1'b0; wr = 1'b0; mreq3 = 1'b1;
        re_cnt = 0;
        @(negedge clk);
        chk("abort_c0_wait", 32'(wait3), 1);
        if (mem_re3) re_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_c1_wait", 32'(wait3), 1);
        if (mem_re3) re_cnt++;
        @(posedge clk); #1;
        mreq3 = 1'b0;
        @(negedge clk);
        chk("abort_c2_wait", 32'(wait3), 0);
        if (mem_re3) re_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        if (mem_re3) re_cnt++;
        chk("abort_state_idle", 32'(dbg_state3), 0);
        chk("abort_di", 32'(di3), 32'hFF);
        chk("abort_no_strobe", 32'(re_cnt), 0);
        @(posedge clk); #1;
        // The next request on that instance runs to completion.
        mreq3 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("after_abort_wait", 32'(wait3), (k <= 3) ? 1 : 0);
            chk("after_abort_re", 32'(mem_re3), (k == 3) ? 1 : 0);
            if (k == 4) chk("after_abort_di", 32'(di3), 32'hC7);
            @(posedge clk); #1;
        end
        mreq3 = 1'b0;
        idle(1);

        // Asynchronous reset in the middle of a wait-stated ROM read.
        mreq = 1'b1; iorq = 1'b0; m1 = 1'b0; wr = 1'b0; addr = 16'h0002;
        @(posedge clk); #3;
        chk("pre_rst_re", 32'(mem_re), 1);
        rst = 1'b1;
        #1;
        chk("midrst_wait", 32'(wait_o), 0);
        chk("midrst_di", 32'(di), 32'hFF);
        chk("midrst_state", 32'(dbg_state), 0);
        chk("midrst_re", 32'(mem_re), 0);
        chk("midrst_mem_addr", 32'(mem_addr), 0);
        chk("midrst_fc", 32'(fetch_cnt), 0);
        mreq = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_fc = 16'h0000; m_s0 = 8'h00; m_s1 = 8'h00; m_sh = 8'h00;
        idle(1);
        access(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00, g_di, g_w);
        chk("post_rst_scratch0", 32'(g_di), 0);
        access(1'b1, 1'b0, 1'b0, 16'h0011, 8'h00, g_di, g_w);
        chk("post_rst_scratch1", 32'(g_di), 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
